result_collector: RTL

- Downstream drain stage for the 16x16 systolic multiplier array.
- Once armed, waits for the array's all_done, then walks the array's result read port (addr1/addr2 -> dout) in row-major order.
- Streams every 23-bit signed result out on a valid/ready interface, with optional saturation to a narrower width.
- A 2-entry output buffer absorbs backpressure without losing or duplicating results.

---
 rtl/result_collector.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/result_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : result_collector
// Drains the systolic array result port in row-major order onto valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
module result_collector #(
  parameter int N      = 16,
  parameter int IN_W   = 23,
  parameter int OUT_W  = 23,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     all_done,
  output logic [ADDR_W-1:0]        addr1,
  output logic [ADDR_W-1:0]        addr2,
  input  logic signed [IN_W-1:0]   dout,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_data,
  output logic [ADDR_W-1:0]        m_row,
  output logic [ADDR_W-1:0]        m_col,
  output logic                     m_last,
  output logic                     sat_flag,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [ADDR_W-1:0] C_MAX = ADDR_W'(N - 1);

  logic [1:0]               r_state;
  logic [1:0]               r_count;
  logic                     r_rd_ptr;
  logic                     r_wr_ptr;
  logic signed [OUT_W-1:0]  r_data [2];
  logic [ADDR_W-1:0]        r_row  [2];
  logic [ADDR_W-1:0]        r_col  [2];
  logic                     r_last [2];

  logic signed [OUT_W-1:0]  w_sat_data;
  logic                     w_clamped;
  logic                     w_pop;
  logic                     w_cap;
  logic                     w_at_end;

  generate
    if (OUT_W < IN_W) begin : g_sat
      localparam logic signed [IN_W-1:0] C_HI = IN_W'((2 ** (OUT_W - 1)) - 1);
      localparam logic signed [IN_W-1:0] C_LO = IN_W'(-(2 ** (OUT_W - 1)));
      always_comb begin
        w_sat_data = dout[OUT_W-1:0];
        w_clamped  = 1'b0;
        if (dout > C_HI) begin
          w_sat_data = C_HI[OUT_W-1:0];
          w_clamped  = 1'b1;
        end else if (dout < C_LO) begin
          w_sat_data = C_LO[OUT_W-1:0];
          w_clamped  = 1'b1;
        end
      end
    end else begin : g_pass
      assign w_sat_data = OUT_W'(dout);
      assign w_clamped  = 1'b0;
    end
  endgenerate

  assign m_valid  = (r_count != 2'd0);
  assign m_data   = r_data[r_rd_ptr];
  assign m_row    = r_row[r_rd_ptr];
  assign m_col    = r_col[r_rd_ptr];
  assign m_last   = r_last[r_rd_ptr];
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FLUSH) && (r_count == 2'd0);

  assign w_pop    = m_valid && m_ready;
  // A full buffer can still accept a capture when its head leaves on the same edge.
  assign w_cap    = (r_state == S_READ) && ((r_count != 2'd2) || w_pop);
  assign w_at_end = (addr1 == C_MAX) && (addr2 == C_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      addr1    <= '0;
      addr2    <= '0;
      sat_flag <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_row[i]  <= '0;
        r_col[i]  <= '0;
        r_last[i] <= 1'b0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state  <= S_WAIT;
            sat_flag <= 1'b0;
            addr1    <= '0;
            addr2    <= '0;
          end
        end
        S_WAIT: begin
          if (all_done) r_state <= S_READ;
        end
        S_READ: begin
          if (w_cap && w_at_end) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_count == 2'd0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_cap) begin
        r_data[r_wr_ptr] <= w_sat_data;
        r_row[r_wr_ptr]  <= addr1;
        r_col[r_wr_ptr]  <= addr2;
        r_last[r_wr_ptr] <= w_at_end;
        r_wr_ptr         <= ~r_wr_ptr;
        if (w_clamped) sat_flag <= 1'b1;
        if (!w_at_end) begin
          if (addr2 == C_MAX) begin
            addr2 <= '0;
            addr1 <= addr1 + 1'b1;
          end else begin
            addr2 <= addr2 + 1'b1;
          end
        end
      end

      if (w_pop) r_rd_ptr <= ~r_rd_ptr;

      unique case ({w_cap, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire
